// File: rtl/ksa_serial_add_ctrl.sv
// ksa_serial_add_ctrl: nibble-serial wide adder built around a single 4-bit
// Kogge-Stone slice with carry-in. It captures an operand pair from a
// valid/ready producer and adds one nibble per clock, least significant
// nibble first. The inter-nibble carry is held in a flop. The result (sum,
// carry-out, signed overflow) is then presented to a valid/ready consumer.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer has an operand pair on a/b/cin
//   in_ready   block is idle and can accept an operand pair
//   a, b       W-bit operands (unsigned or two's complement)
//   cin        carry into nibble 0
//   out_valid  sum/cout/ovf are valid
//   out_ready  consumer accepts the result
//   sum        registered a+b+cin modulo 2^W
//   cout       registered carry out of bit W-1
//   ovf        registered signed overflow
//   busy       operation in progress or result pending
module ksa_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = $clog2(NIBBLES);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  // Kogge-Stone 4-bit slice on the current nibble
  logic [3:0] nib_a, nib_b, g, p, s4;
  logic       g0c, g10, g21, g32, p21, p32, c1, c2, c3, c4;

  always_comb begin
    nib_a = a_q[{cnt_q, 2'b00} +: 4];
    nib_b = b_q[{cnt_q, 2'b00} +: 4];
    g     = nib_a & nib_b;
    p     = nib_a ^ nib_b;
    // Fold carry-in into bit 0 generate so the prefix tree needs no extra column
    g0c   = g[0] | (p[0] & carry_q);
    // Level 1: span 2
    g10   = g[1] | (p[1] & g0c);
    g21   = g[2] | (p[2] & g[1]);
    p21   = p[2] & p[1];
    g32   = g[3] | (p[3] & g[2]);
    p32   = p[3] & p[2];
    // Level 2: span 4
    c1    = g0c;
    c2    = g10;
    c3    = g21 | (p21 & g0c);
    c4    = g32 | (p32 & g10);
    s4    = p ^ {c3, c2, c1, carry_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{cnt_q, 2'b00} +: 4] = s4;
        carry_d = c4;
        if (cnt_q == LastCnt) begin
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/ksa_serial_add_ctrl.md
Name: ksa_serial_add_ctrl

Overview:
- Sequencer that reuses one 4-bit Kogge-Stone add slice (with carry-in) to add two wide operands nibble-serially, least significant nibble first.
- Sits between a valid/ready producer and a valid/ready consumer.
- Captures operands, runs one nibble per clock, carries between nibbles in a flop, and presents sum, carry-out and signed overflow.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; must be >= 2.
- W, 4*NIBBLES (derived, localparam), operand and sum width in bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has an operand pair on a/b/cin.
- in_ready  output  1  block can accept an operand pair.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  registered result a+b+cin, modulo 2^W.
- cout  output  1  registered carry out of bit W-1.
- ovf  output  1  registered signed overflow: carry into bit W-1 XOR carry out of bit W-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces state=IDLE, nibble counter=0, carry flop=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0. Reset acts immediately, not at the next edge.
- Combinational outputs:
  - in_ready = (state==IDLE). It is high while rst_n is low.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On an edge with in_valid&&in_ready, capture a, b and cin.
  - Set carry=cin and cnt=0, then go to RUN.
  - sum, cout and ovf keep the last result until overwritten.
- RUN, every edge:
  - {c4,s4} = a_reg[4cnt+:4] + b_reg[4cnt+:4] + carry, as a 5-bit result.
  - sum[4cnt+:4] <= s4; carry <= c4; cnt <= cnt+1.
  - When cnt==NIBBLES-1:
    - cout <= c4.
    - ovf <= c3 ^ c4, where c3 is the internal carry into bit 3 of the top nibble.
    - cnt <= 0; go to DONE.
  - a, b, cin and in_valid are ignored during RUN; the block works only on the captured operands.
- sum is built in place. The upper nibbles of sum hold the previous result until overwritten. Consumers may only sample sum while out_valid is high.
- DONE:
  - sum, cout and ovf are held stable while out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1, go to IDLE.
  - A new operand pair can be accepted no earlier than the following edge, so there is no overlap.
- Latency: accept on edge k, out_valid rises after edge k+NIBBLES. Minimum issue interval is NIBBLES+2 cycles.
- out_ready while not in DONE is ignored.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No partial result is output.
- cnt width is clog2(NIBBLES). cnt never exceeds NIBBLES-1.
- Illegal state encodings recover to IDLE.

Test Plan (NIBBLES=4):
- Reset, then a=0x0000, b=0x0000, cin=0, in_valid for 1 cycle -> in_ready drops the next cycle. out_valid rises 4 edges after accept with sum=0x0000, cout=0, ovf=0. With out_ready=1, in_ready is high again 1 cycle later.
- a=0x00FF, b=0x0001, cin=0 (inter-nibble carry chain) -> sum=0x0100, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- a=0xA5A5, b=0x5A5A, cin=1, with out_ready=0 for 5 cycles after out_valid -> sum=0x0000, cout=1, ovf=0, held stable; busy=1 and in_ready=0 throughout. A second in_valid with a=0x1234 during RUN/DONE is not accepted. Result is released on the first out_ready=1.
- Start a=0x1111, b=0x2222, drop rst_n after 2 RUN edges -> immediately out_valid=0, busy=0, sum=0, in_ready=1. After release, a=0x1111, b=0x2222 gives sum=0x3333, cout=0.
- 8 random operand pairs, with out_ready randomly toggled -> each result equals (a+b+cin) mod 2^16, cout equals bit 16 of the sum, and ovf equals signed overflow, compared against a behavioural model.
